// File: rtl/vehicle_sensor_pkg.sv
// Shared types and constants for the vehicle sensor front end: channel FSM
// states, loop channel indices, widths and the saturating count helper.
package vehicle_sensor_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RISE_CHK = 2'd1,
      PRESENT  = 2'd2,
      FALL_CHK = 2'd3
   } ch_state_e;

   localparam int A1 = 0;
   localparam int A2 = 1;
   localparam int B1 = 2;
   localparam int B2 = 3;

   localparam int COUNT_W    = 8;
   localparam int TICK_CNT_W = 16;
   localparam int STUCK_W    = 24;

   // Sum is formed one bit wider so 254 + 2 still clamps to 255.
   function automatic logic [COUNT_W-1:0] sat_add(input logic [COUNT_W-1:0] cnt,
                                                  input logic x, input logic y);
      logic [COUNT_W:0] sum;
      sum = {1'b0, cnt} + {{COUNT_W{1'b0}}, x} + {{COUNT_W{1'b0}}, y};
      return sum[COUNT_W] ? {COUNT_W{1'b1}} : sum[COUNT_W-1:0];
   endfunction

endpackage

// File: rtl/vehicle_sensor_frontend_if.sv
// Sensor-side bundle towards traffic_light_top: conditioned presence, arrival
// counts and stuck flags. The front end drives it (master), consumers read it (slave).
interface vehicle_sensor_frontend_if;
   import vehicle_sensor_pkg::*;

   logic               AS1;
   logic               AS2;
   logic               BS1;
   logic               BS2;
   logic [COUNT_W-1:0] a_count;
   logic [COUNT_W-1:0] b_count;
   logic [3:0]         fault;

   modport master (output AS1, AS2, BS1, BS2, a_count, b_count, fault);
   modport slave  (input  AS1, AS2, BS1, BS2, a_count, b_count, fault);
endinterface

// File: rtl/sensor_channel.sv
// One loop channel: 2-flop synchroniser, debounce/hold FSM and, with
// SENSOR_STUCK_DETECT_EN defined, a stuck-presence detector with fail-safe recall.
module sensor_channel
   import vehicle_sensor_pkg::*;
#(
   parameter int unsigned DEBOUNCE_TICKS = 20,
   parameter int unsigned HOLD_TICKS     = 500,
   parameter int unsigned STUCK_TICKS    = 60000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sync_in,
   input  logic tick,
   input  logic count_clr,
   output logic present,
   output logic arrive,
   output logic fault
);

   logic                  sync1_q, sync1_d, sync2_q, sync2_d;
   ch_state_e             state_q, state_d;
   logic [TICK_CNT_W-1:0] cnt_q, cnt_d;
   logic                  present_q, present_d;
   logic                  arrive_raw;
   logic                  fault_int;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         state_q   <= IDLE;
         cnt_q     <= '0;
         present_q <= 1'b0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         present_q <= present_d;
      end
   end

   always_comb begin
      sync1_d    = sync_in;
      sync2_d    = sync1_q;
      state_d    = state_q;
      cnt_d      = cnt_q;
      arrive_raw = 1'b0;
      case (state_q)
         IDLE: begin
            if (sync2_q) begin
               state_d = RISE_CHK;
               cnt_d   = '0;
            end
         end
         RISE_CHK: begin
            if (!sync2_q) begin
               state_d = IDLE;
            end else if (tick) begin
               if (cnt_q == TICK_CNT_W'(DEBOUNCE_TICKS - 1)) begin
                  state_d    = PRESENT;
                  arrive_raw = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         PRESENT: begin
            if (!sync2_q) begin
               state_d = FALL_CHK;
               cnt_d   = '0;
            end
         end
         FALL_CHK: begin
            // A vehicle returning inside the hold window is the same demand, not a new arrival.
            if (sync2_q) begin
               state_d = PRESENT;
            end else if (tick) begin
               if (cnt_q == TICK_CNT_W'(HOLD_TICKS - 1)) begin
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      present_d = (state_q == PRESENT) || (state_q == FALL_CHK) || fault_int;
   end

`ifdef SENSOR_STUCK_DETECT_EN
   logic [STUCK_W-1:0] stuck_q, stuck_d;
   logic               fault_q, fault_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stuck_q <= '0;
         fault_q <= 1'b0;
      end else begin
         stuck_q <= stuck_d;
         fault_q <= fault_d;
      end
   end

   // Counter is held at zero outside PRESENT, so every entry restarts it.
   always_comb begin
      stuck_d = '0;
      if (state_q == PRESENT) begin
         stuck_d = stuck_q;
         if (tick && (stuck_q != STUCK_W'(STUCK_TICKS))) begin
            stuck_d = stuck_q + 1'b1;
         end
      end
      if (count_clr) begin
         fault_d = 1'b0;
      end else begin
         fault_d = fault_q || ((state_q == PRESENT) && (stuck_q == STUCK_W'(STUCK_TICKS)));
      end
   end

   assign fault_int = fault_q;
`else
   logic unused_stuck;
   assign unused_stuck = count_clr & (STUCK_TICKS == 0);
   assign fault_int    = 1'b0;
`endif

   assign present = present_q;
   assign arrive  = arrive_raw & ~fault_int;
   assign fault   = fault_int;

endmodule

// File: rtl/vehicle_sensor_frontend.sv
// Top of the loop-detector front end: shared tick prescaler, four channels and
// the saturating A/B arrival counters. Optional macro: SENSOR_STUCK_DETECT_EN.
module vehicle_sensor_frontend
   import vehicle_sensor_pkg::*;
#(
   parameter int unsigned TICK_DIV       = 50000,
   parameter int unsigned DEBOUNCE_TICKS = 20,
   parameter int unsigned HOLD_TICKS     = 500,
   parameter int unsigned STUCK_TICKS    = 60000
) (
   input  logic                       clk_50M,
   input  logic                       reset_btn_n,
   input  logic [3:0]                 loop_raw,
   input  logic                       count_clr,
   vehicle_sensor_frontend_if.master  sns
);

   localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [PRESC_W-1:0] presc_q, presc_d;
   logic               tick;
   logic [COUNT_W-1:0] a_count_q, a_count_d, b_count_q, b_count_d;
   logic [3:0]         present_vec, arrive_vec, fault_vec;

   always_ff @(posedge clk_50M or negedge reset_btn_n) begin
      if (!reset_btn_n) begin
         presc_q   <= '0;
         a_count_q <= '0;
         b_count_q <= '0;
      end else begin
         presc_q   <= presc_d;
         a_count_q <= a_count_d;
         b_count_q <= b_count_d;
      end
   end

   always_comb begin
      tick    = (presc_q == PRESC_W'(TICK_DIV - 1));
      presc_d = tick ? '0 : presc_q + 1'b1;
      // A clear wins over any arrival landing in the same cycle.
      if (count_clr) begin
         a_count_d = '0;
         b_count_d = '0;
      end else begin
         a_count_d = sat_add(a_count_q, arrive_vec[A1], arrive_vec[A2]);
         b_count_d = sat_add(b_count_q, arrive_vec[B1], arrive_vec[B2]);
      end
   end

   for (genvar i = 0; i < 4; i++) begin : g_ch
      sensor_channel #(
         .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
         .HOLD_TICKS     (HOLD_TICKS),
         .STUCK_TICKS    (STUCK_TICKS)
      ) u_ch (
         .clk       (clk_50M),
         .rst_n     (reset_btn_n),
         .sync_in   (loop_raw[i]),
         .tick      (tick),
         .count_clr (count_clr),
         .present   (present_vec[i]),
         .arrive    (arrive_vec[i]),
         .fault     (fault_vec[i])
      );
   end

   assign sns.AS1     = present_vec[A1];
   assign sns.AS2     = present_vec[A2];
   assign sns.BS1     = present_vec[B1];
   assign sns.BS2     = present_vec[B2];
   assign sns.a_count = a_count_q;
   assign sns.b_count = b_count_q;
   assign sns.fault   = fault_vec;

endmodule

// File: tb/tb_vehicle_sensor_frontend.sv
// Directed bench for vehicle_sensor_frontend with TICK_DIV=4, DEBOUNCE=3,
// HOLD=5, STUCK=20; stuck checks follow SENSOR_STUCK_DETECT_EN.
module tb_vehicle_sensor_frontend;

   logic       clk_50M;
   logic       reset_btn_n;
   logic [3:0] loop_raw;
   logic       count_clr;
   int         cyc;
   int         n_tests;
   int         n_fail;

   vehicle_sensor_frontend_if sns ();

   vehicle_sensor_frontend #(
      .TICK_DIV       (4),
      .DEBOUNCE_TICKS (3),
      .HOLD_TICKS     (5),
      .STUCK_TICKS    (20)
   ) dut (
      .clk_50M     (clk_50M),
      .reset_btn_n (reset_btn_n),
      .loop_raw    (loop_raw),
      .count_clr   (count_clr),
      .sns         (sns)
   );

   // Clock and reset-relative edge counter (prescaler phase = cyc % 4)
   initial clk_50M = 1'b0;
   always #10 clk_50M = ~clk_50M;

   always @(posedge clk_50M or negedge reset_btn_n) begin
      if (!reset_btn_n) cyc <= 0;
      else              cyc <= cyc + 1;
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk_50M);
      #1;
   endtask

   task automatic pulse_clear();
      count_clr = 1'b1;
      wait_cycles(1);
      count_clr = 1'b0;
   endtask

   task automatic test_reset();
      int lat;
      reset_btn_n = 1'b0;
      loop_raw    = 4'hF;
      count_clr   = 1'b0;
      wait_cycles(6);
      n_tests++;
      if ({sns.AS1, sns.AS2, sns.BS1, sns.BS2} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_presence: got %b expected 0000", {sns.AS1, sns.AS2, sns.BS1, sns.BS2});
      end
      n_tests++;
      if (sns.a_count !== 8'd0) begin
         n_fail++; $display("FAIL reset_a_count: got %0d expected 0", sns.a_count);
      end
      n_tests++;
      if (sns.b_count !== 8'd0) begin
         n_fail++; $display("FAIL reset_b_count: got %0d expected 0", sns.b_count);
      end
      n_tests++;
      if (sns.fault !== 4'b0000) begin
         n_fail++; $display("FAIL reset_fault: got %b expected 0000", sns.fault);
      end
      reset_btn_n = 1'b1;
      lat = 0;
      while (sns.AS1 !== 1'b1 && lat < 30) begin
         wait_cycles(1);
         lat++;
      end
      n_tests++;
      if (lat > 16) begin
         n_fail++; $display("FAIL reset_as1_rise: latency %0d expected <= 16", lat);
      end
      n_tests++;
      if (sns.a_count !== 8'd2) begin
         n_fail++; $display("FAIL reset_a_count_after: got %0d expected 2", sns.a_count);
      end
      n_tests++;
      if (sns.b_count !== 8'd2) begin
         n_fail++; $display("FAIL reset_b_count_after: got %0d expected 2", sns.b_count);
      end
      loop_raw = 4'h0;
      wait_cycles(40);
      n_tests++;
      if ({sns.AS1, sns.AS2, sns.BS1, sns.BS2} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_release_all: got %b expected 0000", {sns.AS1, sns.AS2, sns.BS1, sns.BS2});
      end
   endtask

   task automatic test_glitch();
      logic seen;
      pulse_clear();
      loop_raw[2] = 1'b1;
      wait_cycles(3);
      loop_raw[2] = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         wait_cycles(1);
         if (sns.BS1 !== 1'b0) seen = 1'b1;
      end
      n_tests++;
      if (seen !== 1'b0) begin
         n_fail++; $display("FAIL glitch_bs1: BS1 rose, expected to stay 0");
      end
      n_tests++;
      if (sns.b_count !== 8'd0) begin
         n_fail++; $display("FAIL glitch_b_count: got %0d expected 0", sns.b_count);
      end
   endtask

   task automatic test_gap_hold();
      logic dropped;
      int   lat;
      loop_raw[1] = 1'b1;
      wait_cycles(40);
      n_tests++;
      if (sns.AS2 !== 1'b1) begin
         n_fail++; $display("FAIL gap_as2_on: got %b expected 1", sns.AS2);
      end
      dropped = 1'b0;
      loop_raw[1] = 1'b0;
      for (int i = 0; i < 12; i++) begin
         wait_cycles(1);
         if (sns.AS2 !== 1'b1) dropped = 1'b1;
      end
      loop_raw[1] = 1'b1;
      for (int i = 0; i < 40; i++) begin
         wait_cycles(1);
         if (sns.AS2 !== 1'b1) dropped = 1'b1;
      end
      n_tests++;
      if (dropped !== 1'b0) begin
         n_fail++; $display("FAIL gap_as2_held: AS2 dropped during short gap");
      end
      n_tests++;
      if (sns.a_count !== 8'd1) begin
         n_fail++; $display("FAIL gap_a_count: got %0d expected 1", sns.a_count);
      end
      loop_raw[1] = 1'b0;
      lat = 0;
      while (sns.AS2 !== 1'b0 && lat < 60) begin
         wait_cycles(1);
         lat++;
      end
      n_tests++;
      if (lat < 16 || lat > 24) begin
         n_fail++; $display("FAIL gap_release: latency %0d expected 16..24", lat);
      end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 127; i++) begin
         loop_raw[3:2] = 2'b11; wait_cycles(20);
         loop_raw[3:2] = 2'b00; wait_cycles(30);
      end
      n_tests++;
      if (sns.b_count !== 8'd254) begin
         n_fail++; $display("FAIL sat_254: got %0d expected 254", sns.b_count);
      end
      loop_raw[3:2] = 2'b11; wait_cycles(20);
      loop_raw[3:2] = 2'b00; wait_cycles(30);
      n_tests++;
      if (sns.b_count !== 8'd255) begin
         n_fail++; $display("FAIL sat_254_plus_2: got %0d expected 255", sns.b_count);
      end
      for (int i = 0; i < 132; i++) begin
         loop_raw[3:2] = 2'b11; wait_cycles(20);
         loop_raw[3:2] = 2'b00; wait_cycles(30);
      end
      n_tests++;
      if (sns.b_count !== 8'd255) begin
         n_fail++; $display("FAIL sat_hold: got %0d expected 255", sns.b_count);
      end
      n_tests++;
      if (sns.a_count !== 8'd1) begin
         n_fail++; $display("FAIL sat_a_isolated: got %0d expected 1", sns.a_count);
      end
      pulse_clear();
      n_tests++;
      if (sns.b_count !== 8'd0 || sns.a_count !== 8'd0) begin
         n_fail++;
         $display("FAIL sat_clear: got a=%0d b=%0d expected 0/0", sns.a_count, sns.b_count);
      end
   endtask

   task automatic test_clear_collision();
      int guard;
      guard = 0;
      while ((cyc % 4) != 0 && guard < 8) begin
         wait_cycles(1);
         guard++;
      end
      // Raw rise after edge e (e%4==0): RISE_CHK at e+3, ticks at e+4/e+8/e+12, arrive before edge e+12.
      loop_raw[0] = 1'b1;
      wait_cycles(11);
      count_clr = 1'b1;
      wait_cycles(1);
      count_clr = 1'b0;
      wait_cycles(4);
      n_tests++;
      if (sns.AS1 !== 1'b1) begin
         n_fail++; $display("FAIL collide_as1: got %b expected 1", sns.AS1);
      end
      n_tests++;
      if (sns.a_count !== 8'd0) begin
         n_fail++; $display("FAIL collide_a_count: got %0d expected 0", sns.a_count);
      end
      loop_raw[0] = 1'b0;
      wait_cycles(40);
      n_tests++;
      if (sns.AS1 !== 1'b0) begin
         n_fail++; $display("FAIL collide_as1_release: got %b expected 0", sns.AS1);
      end
   endtask

   task automatic test_stuck();
      int lat;
      loop_raw[3] = 1'b1;
      wait_cycles(120);
`ifdef SENSOR_STUCK_DETECT_EN
      n_tests++;
      if (sns.fault !== 4'b1000) begin
         n_fail++; $display("FAIL stuck_fault_set: got %b expected 1000", sns.fault);
      end
      loop_raw[3] = 1'b0;
      wait_cycles(40);
      n_tests++;
      if (sns.BS2 !== 1'b1) begin
         n_fail++; $display("FAIL stuck_recall: BS2 got %b expected 1", sns.BS2);
      end
      n_tests++;
      if (sns.b_count !== 8'd1) begin
         n_fail++; $display("FAIL stuck_b_count: got %0d expected 1", sns.b_count);
      end
      pulse_clear();
      lat = 0;
      while (sns.BS2 !== 1'b0 && lat < 30) begin
         wait_cycles(1);
         lat++;
      end
      n_tests++;
      if (sns.fault !== 4'b0000) begin
         n_fail++; $display("FAIL stuck_fault_clear: got %b expected 0000", sns.fault);
      end
      n_tests++;
      if (sns.BS2 !== 1'b0) begin
         n_fail++; $display("FAIL stuck_bs2_release: BS2 got %b expected 0", sns.BS2);
      end
`else
      n_tests++;
      if (sns.fault !== 4'b0000) begin
         n_fail++; $display("FAIL nostuck_fault: got %b expected 0000", sns.fault);
      end
      n_tests++;
      if (sns.b_count !== 8'd1) begin
         n_fail++; $display("FAIL nostuck_b_count: got %0d expected 1", sns.b_count);
      end
      loop_raw[3] = 1'b0;
      lat = 0;
      while (sns.BS2 !== 1'b0 && lat < 60) begin
         wait_cycles(1);
         lat++;
      end
      n_tests++;
      if (lat < 16 || lat > 24) begin
         n_fail++; $display("FAIL nostuck_release: latency %0d expected 16..24", lat);
      end
`endif
   endtask

   initial begin
      n_tests     = 0;
      n_fail      = 0;
      reset_btn_n = 1'b0;
      loop_raw    = 4'h0;
      count_clr   = 1'b0;
      wait_cycles(1);
      test_reset();
      test_glitch();
      test_gap_hold();
      test_saturation();
      test_clear_collision();
      test_stuck();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/vehicle_sensor_frontend.md
# vehicle_sensor_frontend

Conditioning front end that turns the four raw inductive-loop detector inputs into the clean presence signals AS1, AS2, BS1 and BS2 consumed by `traffic_light_top`. It drives the sensor side of the controller's sensor interface. Each raw input is synchronised, debounced and given an extension hold so short gaps between vehicles do not drop the demand. The block also keeps per-approach vehicle arrival counts for the video status display.

## Interface
- `TICK_DIV`, 50000: `clk_50M` cycles per tick (1 ms at 50 MHz).
- `DEBOUNCE_TICKS`, 20: consecutive high ticks required to accept presence.
- `HOLD_TICKS`, 500: low ticks required before presence is released.
- `STUCK_TICKS`, 60000: continuous-presence ticks before a stuck fault (only with `SENSOR_STUCK_DETECT_EN`).
- `clk_50M` input 1: single system clock.
- `reset_btn_n` input 1: asynchronous, active-low reset.
- `loop_raw` input 4: raw loop inputs; bit 0 = A1, bit 1 = A2, bit 2 = B1, bit 3 = B2. Asynchronous.
- `count_clr` input 1: synchronous clear of counts and faults.
- `AS1`, `AS2`, `BS1`, `BS2` output 1 each: conditioned presence, registered.
- `a_count` output 8: saturating count of arrivals on A1 + A2.
- `b_count` output 8: saturating count of arrivals on B1 + B2.
- `fault` output 4: latched stuck-sensor flags, same bit order as `loop_raw`.

## Operation
- Input path: two-flop synchroniser per bit gives `sync[i]`.
- Tick generator: prescaler runs 0..`TICK_DIV`-1 and pulses `tick` for one cycle at wrap. It is shared by all four channels.
- Per-channel FSM, with tick counter `cnt` of 16 bits:
  - IDLE: `sync`=1 → RISE_CHK, `cnt`←0.
  - RISE_CHK: `sync`=0 → IDLE. On `tick` with `sync`=1: if `cnt`==`DEBOUNCE_TICKS`-1 → PRESENT and emit `arrive` for one cycle; otherwise `cnt`++.
  - PRESENT: `sync`=0 → FALL_CHK, `cnt`←0.
  - FALL_CHK: `sync`=1 → PRESENT, no new arrival. On `tick`: if `cnt`==`HOLD_TICKS`-1 → IDLE; otherwise `cnt`++.
- Presence output is registered and equals 1 when the FSM is in PRESENT or FALL_CHK.
- Counters:
  - `a_count` adds `arrive[0]`+`arrive[1]` each cycle; `b_count` adds `arrive[2]`+`arrive[3]`. Two arrivals in the same cycle add 2.
  - Both saturate at 255. Saturation is checked after the sum, so 254 + 2 gives 255.
- `count_clr` zeroes both counts and `fault`. An arrival in the same cycle as the clear is discarded. The clear has no effect on the FSMs.

## Timing
- Reset values: all FSMs IDLE, all presence outputs 0, counts 0, `fault` 0, prescaler 0, synchroniser 0.
- Raw edge → `sync`: 2 cycles. `sync` → FSM leaves IDLE: 1 cycle.
- Presence assert latency: `DEBOUNCE_TICKS` ticks after RISE_CHK entry, plus 1 cycle for the output register. That is between (`DEBOUNCE_TICKS`-1)·`TICK_DIV` and `DEBOUNCE_TICKS`·`TICK_DIV` cycles, plus 4 cycles.
- Presence release follows the same form using `HOLD_TICKS`.
- Count update is visible 1 cycle after `arrive`.
- A glitch shorter than 1 tick never asserts presence. A gap shorter than the hold time never deasserts it.
- Reset asserted mid-operation returns every register to its reset value immediately, asynchronously. Behaviour restarts from IDLE after deassertion.

## Configuration
- `SENSOR_STUCK_DETECT_EN` defined:
  - Each channel runs a separate counter of 24 bits, active only in PRESENT. It is cleared on entry to PRESENT.
  - When the counter reaches `STUCK_TICKS`, `fault[i]` latches to 1.
  - While `fault[i]`=1, presence is forced to 1 (fail-safe recall) and `arrive[i]` is suppressed.
  - `fault[i]` clears only on `count_clr` or reset.
- `SENSOR_STUCK_DETECT_EN` undefined: no stuck counter, and `fault` is tied to 0.

## Structure
- Package `vehicle_sensor_pkg`: channel FSM state enum (IDLE, RISE_CHK, PRESENT, FALL_CHK), channel index constants (A1=0, A2=1, B1=2, B2=3), count width 8, tick counter width 16.
- Sub-module `sensor_channel`, instantiated 4 times. It contains the synchroniser, FSM, tick counter and optional stuck logic. Its ports are `sync_in`, `tick`, `count_clr`, `present`, `arrive` and `fault`.
- The top level holds the prescaler and the two count accumulators.

## Test plan
All scenarios use `TICK_DIV`=4, `DEBOUNCE_TICKS`=3, `HOLD_TICKS`=5 and `STUCK_TICKS`=20.

1. Reset: hold `reset_btn_n`=0 with `loop_raw`=4'hF → all outputs 0. Release → AS1 rises within 12+4 cycles and `a_count`=2.
2. Glitch: pulse `loop_raw[2]` high for 3 cycles → BS1 stays 0 and `b_count`=0.
3. Gap hold: A2 high for 40 cycles, low for 12 cycles, high again → AS2 stays 1 throughout and `a_count`=1. A2 then low for 30 cycles → AS2 drops between 16 and 20 cycles (+4) after the fall.
4. Saturation: 260 clean pulses on B1 and B2 together → `b_count` reaches 255 and holds. `count_clr` → 0.
5. Clear collision: `count_clr` in the same cycle as an `arrive` on A1 → `a_count`=0 afterwards.
6. With the macro, hold B2 high for 100 cycles → `fault[3]`=1 after 20 ticks. Drop B2 → BS2 stays 1. `count_clr` → `fault[3]`=0 and BS2 drops after the hold time. Without the macro, `fault` stays 0.
